div_unit: RTL and testbench

//  Iterative radix-2 (1 bit/cycle) signed/unsigned divider for MIPS DIV/DIVU in the execute stage.
//  - Drives stall_div, which the hazard unit consumes as stall_divE to hold F/D/E while a divide runs.
//  - Result goes to the HI/LO write path: remainder -> HI, quotient -> LO.

---
 rtl/div_unit.sv | 164 ++++++++++++++++
 tb/tb_div_unit.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for MIPS DIV/DIVU (HI=rem, LO=quo).
//            Optional early-out for |dividend| < |divisor| via DIV_EARLY_OUT_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             signed_div,
  input  logic             annul,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             stall_div,
  output logic             ready,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(WIDTH - 1);

  state_t           r_state;
  state_t           w_nextState;
  logic             w_accept;
  logic             w_divZero;
  logic             w_early;
  logic [WIDTH-1:0] w_absA;
  logic [WIDTH-1:0] w_absB;

  logic             r_signQ;
  logic             r_signR;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_div;
  logic [WIDTH:0]   r_rem;
  logic [CNT_W-1:0] r_count;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;

  logic [WIDTH:0]   w_remShift;
  logic [WIDTH:0]   w_remSub;
  logic             w_fits;
  logic [WIDTH-1:0] w_quoFinal;
  logic [WIDTH-1:0] w_remFinal;

  // Operand magnitudes; DIVU passes operands through untouched.
  assign w_absA    = (signed_div && dividend[WIDTH-1]) ? (~dividend + 1'b1) : dividend;
  assign w_absB    = (signed_div && divisor[WIDTH-1])  ? (~divisor + 1'b1)  : divisor;
  assign w_divZero = (divisor == '0);

`ifdef DIV_EARLY_OUT_EN
  assign w_early = !w_divZero && (w_absA < w_absB);
`else
  assign w_early = 1'b0;
`endif

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  assign w_remShift = {r_rem[WIDTH-1:0], r_quo[WIDTH-1]};
  assign w_remSub   = w_remShift - {1'b0, r_div};
  assign w_fits     = (w_remShift >= {1'b0, r_div});

  assign w_quoFinal = r_signQ ? (~r_quo + 1'b1) : r_quo;
  assign w_remFinal = r_signR ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    w_accept    = 1'b0;
    stall_div   = 1'b0;
    ready       = 1'b0;
    case (r_state)
      IDLE: begin
        if (start && !annul) begin
          w_accept    = 1'b1;
          stall_div   = resetn;
          w_nextState = (w_divZero || w_early) ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall_div = resetn;
        if (annul) begin
          w_nextState = IDLE;
        end else if (r_count == c_lastCount) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        ready       = !annul;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_signQ     <= 1'b0;
      r_signR     <= 1'b0;
      r_quo       <= '0;
      r_div       <= '0;
      r_rem       <= '0;
      r_count     <= '0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (w_accept) begin
        r_count <= '0;
        r_div   <= w_absB;
        // Short-cut results are final as loaded, so sign correction is disabled.
        if (w_divZero) begin
          r_signQ <= 1'b0;
          r_signR <= 1'b0;
          r_quo   <= '1;
          r_rem   <= {1'b0, dividend};
        end else if (w_early) begin
          r_signQ <= 1'b0;
          r_signR <= 1'b0;
          r_quo   <= '0;
          r_rem   <= {1'b0, dividend};
        end else begin
          r_signQ <= signed_div & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
          r_signR <= signed_div & dividend[WIDTH-1];
          r_quo   <= w_absA;
          r_rem   <= '0;
        end
      end else if (r_state == BUSY && !annul) begin
        r_rem   <= w_fits ? w_remSub : w_remShift;
        r_quo   <= {r_quo[WIDTH-2:0], w_fits};
        r_count <= r_count + 1'b1;
      end
      if (ready) begin
        r_quotient  <= w_quoFinal;
        r_remainder <= w_remFinal;
      end
    end
  end

  // Fresh results show on the ready cycle; held copies afterwards.
  assign quotient  = ready ? w_quoFinal : r_quotient;
  assign remainder = ready ? w_remFinal : r_remainder;

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Directed self-checking bench for div_unit.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic        signed_div;
  logic        annul;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        stall_div;
  logic        ready;
  logic [31:0] quotient;
  logic [31:0] remainder;

  int checks;
  int errors;
  int pulses;
  int pos1;
  int pos2;
  int readySeen;

  div_unit #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .signed_div(signed_div),
    .annul     (annul),
    .dividend  (dividend),
    .divisor   (divisor),
    .stall_div (stall_div),
    .ready     (ready),
    .quotient  (quotient),
    .remainder (remainder)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Issue one divide, wait for ready (bounded), check latency, stall length and results.
  task automatic runDiv(input string tag, input logic sd, input logic [31:0] a,
                        input logic [31:0] b, input int expLat,
                        input logic [31:0] expQ, input logic [31:0] expR);
    int lat;
    int stalls;
    lat    = -1;
    stalls = 0;
    @(negedge clk);
    signed_div = sd;
    dividend   = a;
    divisor    = b;
    annul      = 1'b0;
    start      = 1'b1;
    #1;
    if (stall_div) stalls++;
    for (int n = 1; n <= 80; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (ready) begin
        lat = n;
        chk({tag, "_quo"}, quotient, expQ);
        chk({tag, "_rem"}, remainder, expR);
        chk({tag, "_stallAtReady"}, {31'd0, stall_div}, 32'd0);
        break;
      end else if (stall_div) begin
        stalls++;
      end
    end
    chk({tag, "_latency"}, 32'(lat), 32'(expLat));
    chk({tag, "_stallCycles"}, 32'(stalls), 32'(expLat));
    @(posedge clk);
    #1;
    chk({tag, "_readyPulse"}, {31'd0, ready}, 32'd0);
    chk({tag, "_quoHold"}, quotient, expQ);
    chk({tag, "_remHold"}, remainder, expR);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    resetn     = 1'b0;
    start      = 1'b1;
    signed_div = 1'b0;
    annul      = 1'b0;
    dividend   = 32'd0;
    divisor    = 32'd0;

    // Reset state, with start high to show stall_div is suppressed in reset.
    #12;
    chk("rst_stall", {31'd0, stall_div}, 32'd0);
    chk("rst_ready", {31'd0, ready}, 32'd0);
    chk("rst_quo", quotient, 32'd0);
    chk("rst_rem", remainder, 32'd0);
    start = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    runDiv("divu_100_7", 1'b0, 32'd100, 32'd7, 33, 32'd14, 32'd2);
    runDiv("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    runDiv("div_7_m2", 1'b1, 32'd7, 32'hFFFF_FFFE, 33, 32'hFFFF_FFFD, 32'd1);
    runDiv("div_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0);
    runDiv("divu_5_0", 1'b0, 32'd5, 32'd0, 1, 32'hFFFF_FFFF, 32'd5);
    runDiv("div_m8_0", 1'b1, 32'hFFFF_FFF8, 32'd0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFF8);
    runDiv("divu_max_1", 1'b0, 32'hFFFF_FFFF, 32'd1, 33, 32'hFFFF_FFFF, 32'd0);
`ifdef DIV_EARLY_OUT_EN
    runDiv("divu_3_10", 1'b0, 32'd3, 32'd10, 1, 32'd0, 32'd3);
    runDiv("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 1, 32'd0, 32'hFFFF_FFFD);
`else
    runDiv("divu_3_10", 1'b0, 32'd3, 32'd10, 33, 32'd0, 32'd3);
    runDiv("div_m3_10", 1'b1, 32'hFFFF_FFFD, 32'd10, 33, 32'd0, 32'hFFFF_FFFD);
`endif

    // Establish known outputs, then annul DIVU 1000/3 at T+10.
    runDiv("divu_9_4", 1'b0, 32'd9, 32'd4, 33, 32'd2, 32'd1);
    readySeen = 0;
    @(negedge clk);
    signed_div = 1'b0;
    dividend   = 32'd1000;
    divisor    = 32'd3;
    start      = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
      if (ready) readySeen++;
      if (n == 10) annul = 1'b1;
    end
    @(posedge clk);
    #1;
    annul = 1'b0;
    chk("annul_stallT11", {31'd0, stall_div}, 32'd0);
    chk("annul_quoKeep", quotient, 32'd2);
    chk("annul_remKeep", remainder, 32'd1);
    for (int n = 0; n < 40; n++) begin
      @(posedge clk);
      #1;
      if (ready) readySeen++;
    end
    chk("annul_noReady", 32'(readySeen), 32'd0);
    chk("annul_quoStill", quotient, 32'd2);
    runDiv("divu_9_3", 1'b0, 32'd9, 32'd3, 33, 32'd3, 32'd0);

    // start held high for 40 cycles: second accept lands one cycle after the first ready.
    pulses = 0;
    pos1   = -1;
    pos2   = -1;
    @(negedge clk);
    signed_div = 1'b0;
    dividend   = 32'd100;
    divisor    = 32'd7;
    start      = 1'b1;
    for (int n = 1; n <= 90; n++) begin
      @(posedge clk);
      #1;
      if (n == 40) start = 1'b0;
      if (n == 34) chk("held_stallAccept2", {31'd0, stall_div}, 32'd1);
      if (ready) begin
        pulses++;
        if (pulses == 1) pos1 = n;
        if (pulses == 2) pos2 = n;
      end
    end
    chk("held_pulses", 32'(pulses), 32'd2);
    chk("held_pos1", 32'(pos1), 32'd33);
    chk("held_pos2", 32'(pos2), 32'd67);
    chk("held_quo", quotient, 32'd14);

    // Asynchronous reset mid-divide.
    @(negedge clk);
    dividend = 32'd50;
    divisor  = 32'd6;
    start    = 1'b1;
    for (int n = 0; n < 5; n++) begin
      @(posedge clk);
      #1;
      start = 1'b0;
    end
    #2;
    resetn = 1'b0;
    #1;
    chk("midrst_stall", {31'd0, stall_div}, 32'd0);
    chk("midrst_quo", quotient, 32'd0);
    chk("midrst_rem", remainder, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    runDiv("post_rst", 1'b0, 32'd50, 32'd6, 33, 32'd8, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
